opsum_writeback: RTL and testbench



---
 rtl/opsum_writeback_pkg.sv | 27 ++
 rtl/opsum_requant_pipe.sv | 75 +++++++
 rtl/opsum_writeback.sv | 164 ++++++++++++++++
 tb/tb_opsum_writeback.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_writeback_pkg.sv
// rtl/opsum_writeback_pkg.sv - shared types and constants for the opsum writeback block
package opsum_writeback_pkg;

  typedef enum logic {
    MODE_RAW  = 1'b0,
    MODE_INT8 = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  localparam logic [3:0] GLB_WEB_IDLE = 4'hF;

  function automatic logic [31:0] sat_s32(input logic [32:0] v);
    if (v[32] != v[31]) begin
      return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/opsum_requant_pipe.sv
// rtl/opsum_requant_pipe.sv - three-stage bias / multiply / shift-clamp datapath
module opsum_requant_pipe
  import opsum_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  mode_e       mode,
  input  logic        is_bias,
  input  logic [31:0] bias,
  input  logic [15:0] scale,
  input  logic [4:0]  shift,
  input  logic        relu_en,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [2:0]  stage_valid
);

  logic v1, v2, v3;
  logic [31:0] s1, s2_pass;
  logic [47:0] s2;
  logic [32:0] s1_sum;
  logic signed [48:0] s1_ext, scale_ext, s2_prod;
  logic signed [48:0] s3_rnd, s3_round, s3_shifted;
  logic [7:0] s3_byte;

  always_comb begin
    s1_sum = {in_data[31], in_data} + (is_bias ? {bias[31], bias} : 33'd0);

    s1_ext    = 49'($signed(s1));
    scale_ext = 49'($signed({1'b0, scale}));
    s2_prod   = s1_ext * scale_ext;

    // Round half up before the arithmetic shift.
    s3_rnd     = (shift != 5'd0) ? (49'sd1 <<< (shift - 5'd1)) : 49'sd0;
    s3_round   = 49'($signed(s2)) + s3_rnd;
    s3_shifted = s3_round >>> shift;

    if (relu_en && s3_shifted[48]) begin
      s3_byte = 8'h00;
    end else if (s3_shifted > 49'(INT8_MAX)) begin
      s3_byte = 8'h7F;
    end else if (s3_shifted < 49'(INT8_MIN)) begin
      s3_byte = 8'h80;
    end else begin
      s3_byte = s3_shifted[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1       <= '0;
      s2_pass  <= '0;
      s2       <= '0;
      out_data <= '0;
    end else if (!stall) begin
      v1       <= in_valid;
      s1       <= sat_s32(s1_sum);
      v2       <= v1;
      s2_pass  <= s1;
      s2       <= s2_prod[47:0];
      v3       <= v2;
      out_data <= (mode == MODE_RAW) ? s2_pass : {{24{s3_byte[7]}}, s3_byte};
    end
  end

  assign out_valid   = v3;
  assign stage_valid = {v3, v2, v1};

endmodule

// File: rtl/opsum_writeback.sv
// rtl/opsum_writeback.sv - opsum stream requantiser and GLB writer (raw words or packed int8)
module opsum_writeback
  import opsum_writeback_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        done_o,
  input  logic [31:0] opsum_GLB_base_addr_i,
  input  logic [31:0] num_elem_i,
  input  logic        n_tile_is_last_i,
  input  logic        is_bias_i,
  input  logic [31:0] bias_i,
  input  logic [15:0] scale_i,
  input  logic [4:0]  shift_i,
  input  logic        relu_en_i,
  input  logic        psum_valid_i,
  input  logic [31:0] psum_data_i,
  output logic        psum_ready_o,
  output logic        glb_req_o,
  input  logic        glb_grant_i,
  output logic [31:0] glb_addr_o,
  output logic [31:0] glb_write_data_o,
  output logic [3:0]  glb_web_o
);

  state_e state;
  mode_e  mode_q;
  logic [31:0] base_q, num_q, acc_cnt;
  logic [29:0] wr_idx;
  logic [31:0] pack_data;
  logic [1:0]  pack_cnt;
  logic [3:0]  wr_mask;

  logic stall, commit, accept, pipe_empty, flush_ready;
  logic s3_valid;
  logic [31:0] s3_data, word_addr, issue_data;
  logic [7:0]  s3_byte;
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic issue;
  logic [3:0] issue_mask;

  assign stall        = glb_req_o & ~glb_grant_i;
  assign commit       = glb_req_o & glb_grant_i;
  assign psum_ready_o = (state == ST_RUN) & ~stall & (acc_cnt < num_q);
  assign accept       = psum_valid_i & psum_ready_o;
  assign glb_web_o    = commit ? wr_mask : GLB_WEB_IDLE;
  assign pipe_empty   = (stage_valid == '0);
  assign s3_byte      = s3_data[7:0];
  assign word_addr    = base_q + {wr_idx, 2'b00};
  // The last commit and the DONE transition share a cycle so done_o lands one cycle later.
  assign flush_ready  = pipe_empty & (pack_cnt == 2'd0) & (~glb_req_o | commit);

  opsum_requant_pipe u_pipe (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .in_valid    (accept),
    .in_data     (psum_data_i),
    .mode        (mode_q),
    .is_bias     (is_bias_i),
    .bias        (bias_i),
    .scale       (scale_i),
    .shift       (shift_i),
    .relu_en     (relu_en_i),
    .out_valid   (s3_valid),
    .out_data    (s3_data),
    .stage_valid (stage_valid)
  );

  always_comb begin
    issue      = 1'b0;
    issue_data = s3_data;
    issue_mask = 4'h0;
    if (!stall && s3_valid) begin
      if (mode_q == MODE_RAW) begin
        issue = 1'b1;
      end else if (pack_cnt == 2'd3) begin
        issue      = 1'b1;
        issue_data = {s3_byte, pack_data[23:0]};
      end
    end else if (state == ST_FLUSH && pipe_empty && pack_cnt != 2'd0 && !glb_req_o) begin
      issue      = 1'b1;
      issue_data = pack_data;
      issue_mask = 4'hF << pack_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      mode_q           <= MODE_RAW;
      base_q           <= '0;
      num_q            <= '0;
      acc_cnt          <= '0;
      wr_idx           <= '0;
      pack_data        <= '0;
      pack_cnt         <= '0;
      wr_mask          <= GLB_WEB_IDLE;
      done_o           <= 1'b0;
      glb_req_o        <= 1'b0;
      glb_addr_o       <= '0;
      glb_write_data_o <= '0;
    end else begin
      done_o <= 1'b0;

      if (issue) begin
        glb_req_o        <= 1'b1;
        glb_addr_o       <= word_addr;
        glb_write_data_o <= issue_data;
        wr_mask          <= issue_mask;
        wr_idx           <= wr_idx + 30'd1;
      end else if (commit) begin
        glb_req_o <= 1'b0;
      end

      if (accept) begin
        acc_cnt <= acc_cnt + 32'd1;
      end

      if (!stall && s3_valid && mode_q == MODE_INT8) begin
        if (pack_cnt == 2'd3) begin
          pack_cnt  <= 2'd0;
          pack_data <= '0;
        end else begin
          pack_data[{pack_cnt, 3'b000} +: 8] <= s3_byte;
          pack_cnt <= pack_cnt + 2'd1;
        end
      end else if (issue) begin
        pack_cnt  <= 2'd0;
        pack_data <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state     <= ST_RUN;
            base_q    <= {opsum_GLB_base_addr_i[31:2], 2'b00};
            num_q     <= num_elem_i;
            mode_q    <= n_tile_is_last_i ? MODE_INT8 : MODE_RAW;
            acc_cnt   <= '0;
            wr_idx    <= '0;
            pack_cnt  <= '0;
            pack_data <= '0;
          end
        end
        ST_RUN: begin
          if (acc_cnt == num_q) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_ready) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opsum_writeback.sv
// tb/tb_opsum_writeback.sv - self-checking bench for opsum_writeback
module tb_opsum_writeback;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        done_o;
  logic [31:0] opsum_GLB_base_addr_i;
  logic [31:0] num_elem_i;
  logic        n_tile_is_last_i;
  logic        is_bias_i;
  logic [31:0] bias_i;
  logic [15:0] scale_i;
  logic [4:0]  shift_i;
  logic        relu_en_i;
  logic        psum_valid_i;
  logic [31:0] psum_data_i;
  logic        psum_ready_o;
  logic        glb_req_o;
  logic        glb_grant_i;
  logic [31:0] glb_addr_o;
  logic [31:0] glb_write_data_o;
  logic [3:0]  glb_web_o;

  opsum_writeback #(.PIPE_DEPTH(3)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_i               (start_i),
    .done_o                (done_o),
    .opsum_GLB_base_addr_i (opsum_GLB_base_addr_i),
    .num_elem_i            (num_elem_i),
    .n_tile_is_last_i      (n_tile_is_last_i),
    .is_bias_i             (is_bias_i),
    .bias_i                (bias_i),
    .scale_i               (scale_i),
    .shift_i               (shift_i),
    .relu_en_i             (relu_en_i),
    .psum_valid_i          (psum_valid_i),
    .psum_data_i           (psum_data_i),
    .psum_ready_o          (psum_ready_o),
    .glb_req_o             (glb_req_o),
    .glb_grant_i           (glb_grant_i),
    .glb_addr_o            (glb_addr_o),
    .glb_write_data_o      (glb_write_data_o),
    .glb_web_o             (glb_web_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [31:0] c_base;
  int          c_n;
  bit          c_last, c_bias_en, c_relu;
  int          c_bias;
  logic [15:0] c_scale;
  logic [4:0]  c_shift;
  int          gmode, vmode;
  int          pdata[64];

  logic [31:0] e_addr[$];
  logic [31:0] e_data[$];
  logic [3:0]  e_mask[$];
  int          e_src[$];

  int          obs_nwr;
  logic [31:0] obs_w0;
  logic [3:0]  obs_w0_mask, obs_last_mask;

  function automatic longint ref_s1(input int p);
    longint s;
    s = longint'(p) + (c_bias_en ? longint'(c_bias) : 64'sd0);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  function automatic logic [7:0] ref_byte(input int p);
    longint v, sc, lo;
    sc = 0;
    sc[15:0] = c_scale;
    v = ref_s1(p) * sc;
    if (c_shift != 5'd0) v = (v + (64'sd1 <<< (c_shift - 5'd1))) >>> c_shift;
    lo = c_relu ? 64'sd0 : -64'sd128;
    if (v > 64'sd127) v = 64'sd127;
    if (v < lo) v = lo;
    return v[7:0];
  endfunction

  function automatic void build_expected();
    logic [31:0] w;
    logic [3:0]  m;
    int lanes, wi;
    e_addr.delete(); e_data.delete(); e_mask.delete(); e_src.delete();
    if (!c_last) begin
      for (int k = 0; k < c_n; k++) begin
        longint s;
        s = ref_s1(pdata[k]);
        e_addr.push_back(c_base + 32'(4 * k));
        e_data.push_back(s[31:0]);
        e_mask.push_back(4'h0);
        e_src.push_back(k);
      end
    end else begin
      w = 0; lanes = 0; wi = 0;
      for (int k = 0; k < c_n; k++) begin
        w[8*lanes +: 8] = ref_byte(pdata[k]);
        lanes++;
        if (lanes == 4) begin
          e_addr.push_back(c_base + 32'(4 * wi));
          e_data.push_back(w);
          e_mask.push_back(4'h0);
          e_src.push_back(k);
          wi++; w = 0; lanes = 0;
        end
      end
      if (lanes > 0) begin
        m = 4'h0;
        for (int i = lanes; i < 4; i++) m[i] = 1'b1;
        e_addr.push_back(c_base + 32'(4 * wi));
        e_data.push_back(w);
        e_mask.push_back(m);
        e_src.push_back(-1);
      end
    end
  endfunction

  function automatic logic grant_for(input int cyc);
    case (gmode)
      0: return 1'b1;
      1: return (cyc % 2) == 0;
      2: return !(cyc >= 8 && cyc < 13);
      default: return $urandom_range(0, 9) < 6;
    endcase
  endfunction

  task automatic run_pass(input string tag);
    int idx, nwr, last_commit, done_cyc;
    int stall_bad, hold_bad, web_bad, lat_bad, extra;
    bit prev_hold;
    logic [31:0] prev_addr, prev_data, dmask;
    int acc_cyc[64];
    idx = 0; nwr = 0; last_commit = -1; done_cyc = -1;
    stall_bad = 0; hold_bad = 0; web_bad = 0; lat_bad = 0; extra = 0;
    prev_hold = 0; prev_addr = 0; prev_data = 0;
    obs_w0 = 0; obs_w0_mask = 4'hF; obs_last_mask = 4'hF;
    build_expected();

    @(negedge clk);
    opsum_GLB_base_addr_i = c_base;
    num_elem_i            = 32'(c_n);
    n_tile_is_last_i      = c_last;
    is_bias_i             = c_bias_en;
    bias_i                = c_bias;
    scale_i               = c_scale;
    shift_i               = c_shift;
    relu_en_i             = c_relu;
    psum_valid_i          = 1'b0;
    glb_grant_i           = 1'b1;
    start_i               = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      glb_grant_i  = grant_for(cyc);
      psum_valid_i = (idx < c_n) && (vmode == 0 || $urandom_range(0, 9) < 7);
      psum_data_i  = (idx < c_n) ? pdata[idx] : $urandom;
      #1;
      if (glb_req_o && !glb_grant_i && psum_ready_o) stall_bad++;
      if (prev_hold && (!glb_req_o || glb_addr_o != prev_addr || glb_write_data_o != prev_data)) hold_bad++;
      if (glb_req_o && glb_grant_i) begin
        if (nwr < e_addr.size()) begin
          for (int b = 0; b < 4; b++) dmask[8*b +: 8] = e_mask[nwr][b] ? 8'h00 : 8'hFF;
          chk($sformatf("%s w%0d addr", tag, nwr), glb_addr_o, e_addr[nwr]);
          chk($sformatf("%s w%0d web", tag, nwr), {28'd0, glb_web_o}, {28'd0, e_mask[nwr]});
          chk($sformatf("%s w%0d data", tag, nwr), glb_write_data_o & dmask, e_data[nwr] & dmask);
          if (gmode == 0 && vmode == 0 && e_src[nwr] >= 0 && cyc - acc_cyc[e_src[nwr]] != 4) lat_bad++;
        end else begin
          extra++;
        end
        if (nwr == 0) begin
          obs_w0      = glb_write_data_o;
          obs_w0_mask = glb_web_o;
        end
        obs_last_mask = glb_web_o;
        last_commit = cyc;
        nwr++;
      end else if (glb_web_o != 4'hF) begin
        web_bad++;
      end
      prev_hold = glb_req_o && !glb_grant_i;
      prev_addr = glb_addr_o;
      prev_data = glb_write_data_o;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (psum_valid_i && psum_ready_o) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(negedge clk);
    end
    psum_valid_i = 1'b0;
    obs_nwr = nwr;

    chk({tag, " done seen"}, 32'(done_cyc >= 0), 32'd1);
    chk({tag, " write count"}, 32'(nwr), 32'(e_addr.size()));
    chk({tag, " extra writes"}, 32'(extra), 32'd0);
    chk({tag, " done after last commit"}, 32'(done_cyc), 32'(last_commit + 1));
    chk({tag, " ready while stalled"}, 32'(stall_bad), 32'd0);
    chk({tag, " hold stability"}, 32'(hold_bad), 32'd0);
    chk({tag, " idle web"}, 32'(web_bad), 32'd0);
    chk({tag, " latency"}, 32'(lat_bad), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " done pulse width"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " done"}, {31'd0, done_o}, 32'd0);
    chk({tag, " ready"}, {31'd0, psum_ready_o}, 32'd0);
    chk({tag, " req"}, {31'd0, glb_req_o}, 32'd0);
    chk({tag, " addr"}, glb_addr_o, 32'd0);
    chk({tag, " data"}, glb_write_data_o, 32'd0);
    chk({tag, " web"}, {28'd0, glb_web_o}, 32'hF);
  endtask

  typedef struct packed {
    logic [31:0] base;
    logic [7:0]  n;
    logic        last;
    logic        bias_en;
    logic [31:0] bias;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu;
    logic [1:0]  gmode;
    logic [7:0]  exp_nwr;
    logic [31:0] exp_w0;
    logic [3:0]  exp_w0_mask;
    logic [3:0]  exp_last_mask;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] base, input int n, input bit last, input bit bias_en,
                              input logic [31:0] bias, input logic [15:0] scale, input logic [4:0] shift,
                              input bit relu, input int gm, input int enwr, input logic [31:0] ew0,
                              input logic [3:0] ew0m, input logic [3:0] elm);
    vec_t v;
    v.base = base; v.n = 8'(n); v.last = last; v.bias_en = bias_en; v.bias = bias;
    v.scale = scale; v.shift = shift; v.relu = relu; v.gmode = 2'(gm);
    v.exp_nwr = 8'(enwr); v.exp_w0 = ew0; v.exp_w0_mask = ew0m; v.exp_last_mask = elm;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t vecs[NV];
  int tpsum[NV][8];

  initial begin
    logic [31:0] m0;
    int cnt;
    rst = 1'b1; start_i = 0; opsum_GLB_base_addr_i = 0; num_elem_i = 0; n_tile_is_last_i = 0;
    is_bias_i = 0; bias_i = 0; scale_i = 0; shift_i = 0; relu_en_i = 0;
    psum_valid_i = 0; psum_data_i = 0; glb_grant_i = 0;

    vecs[0] = mk(32'h4000, 4, 0, 0, 32'd0, 16'd1, 5'd0, 0, 0, 4, 32'h0000_0001, 4'h0, 4'h0);
    vecs[1] = mk(32'h8000, 4, 1, 1, 32'd10, 16'd3, 5'd2, 0, 0, 1, 32'h8053_0009, 4'h0, 4'h0);
    vecs[2] = mk(32'h0100, 6, 1, 0, 32'd0, 16'd1, 5'd0, 1, 0, 2, 32'h007F_0700, 4'h0, 4'hC);
    vecs[3] = mk(32'h0200, 8, 0, 0, 32'd0, 16'd1, 5'd0, 0, 1, 8, 32'h0000_000A, 4'h0, 4'h0);
    vecs[4] = mk(32'h0300, 8, 1, 0, 32'd0, 16'd2, 5'd1, 0, 2, 2, 32'h0403_0201, 4'h0, 4'h0);
    vecs[5] = mk(32'h0400, 1, 0, 1, 32'h100, 16'd1, 5'd0, 0, 0, 1, 32'h7FFF_FFFF, 4'h0, 4'h0);
    vecs[6] = mk(32'h0500, 1, 0, 1, 32'hFFFF_FF00, 16'd1, 5'd0, 0, 0, 1, 32'h8000_0000, 4'h0, 4'h0);
    vecs[7] = mk(32'h0600, 1, 1, 0, 32'd0, 16'd1, 5'd0, 0, 0, 1, 32'h0000_00FF, 4'hE, 4'hE);
    vecs[8] = mk(32'h0700, 4, 1, 0, 32'd0, 16'd1, 5'd2, 0, 0, 1, 32'h0001_FF02, 4'h0, 4'h0);
    tpsum = '{'{1, -2, 3, -4, 0, 0, 0, 0},
              '{2, -10, 100, -300, 0, 0, 0, 0},
              '{-5, 7, 1000, 0, 20, -1, 0, 0},
              '{10, -20, 30, -40, 50, -60, 70, -80},
              '{1, 2, 3, 4, 5, 6, -7, -8},
              '{32'h7FFF_FFF0, 0, 0, 0, 0, 0, 0, 0},
              '{32'h8000_0010, 0, 0, 0, 0, 0, 0, 0},
              '{-1, 0, 0, 0, 0, 0, 0, 0},
              '{6, -6, 5, -2, 0, 0, 0, 0}};

    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      c_base = vecs[i].base; c_n = int'(vecs[i].n); c_last = vecs[i].last;
      c_bias_en = vecs[i].bias_en; c_bias = vecs[i].bias; c_scale = vecs[i].scale;
      c_shift = vecs[i].shift; c_relu = vecs[i].relu; gmode = int'(vecs[i].gmode); vmode = 0;
      for (int k = 0; k < 8; k++) pdata[k] = tpsum[i][k];
      run_pass($sformatf("vec%0d", i));
      for (int b = 0; b < 4; b++) m0[8*b +: 8] = vecs[i].exp_w0_mask[b] ? 8'h00 : 8'hFF;
      chk($sformatf("vec%0d table nwr", i), 32'(obs_nwr), {24'd0, vecs[i].exp_nwr});
      chk($sformatf("vec%0d table w0", i), obs_w0 & m0, vecs[i].exp_w0 & m0);
      chk($sformatf("vec%0d table w0 web", i), {28'd0, obs_w0_mask}, {28'd0, vecs[i].exp_w0_mask});
      chk($sformatf("vec%0d table last web", i), {28'd0, obs_last_mask}, {28'd0, vecs[i].exp_last_mask});
    end

    // Reset in the middle of a raw pass after two accepted psums.
    @(negedge clk);
    opsum_GLB_base_addr_i = 32'h0900; num_elem_i = 8; n_tile_is_last_i = 0; is_bias_i = 0;
    glb_grant_i = 1; start_i = 1;
    @(negedge clk);
    start_i = 0; cnt = 0;
    for (int g = 0; g < 20 && cnt < 2; g++) begin
      psum_valid_i = 1; psum_data_i = $urandom;
      #1;
      if (psum_ready_o) cnt++;
      @(negedge clk);
    end
    chk("midrst accepted", 32'(cnt), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset("midrst");
    rst = 1'b0;
    cnt = 0;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      #1;
      if (glb_req_o || done_o || psum_ready_o || glb_web_o != 4'hF) cnt++;
    end
    psum_valid_i = 0;
    chk("midrst quiet after reset", 32'(cnt), 32'd0);
    c_base = 32'h0A00; c_n = 7; c_last = 1; c_bias_en = 1; c_bias = 3; c_scale = 5; c_shift = 3;
    c_relu = 0; gmode = 0; vmode = 0;
    for (int k = 0; k < 7; k++) pdata[k] = $urandom_range(0, 400) - 200;
    run_pass("after_rst");

    for (int r = 0; r < 14; r++) begin
      c_base = {$urandom_range(0, 16'hFFFF), 2'b00};
      c_n = $urandom_range(1, 20);
      c_last = $urandom_range(0, 1);
      c_bias_en = $urandom_range(0, 1);
      c_bias = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 2000) - 1000;
      c_scale = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
      c_shift = 5'($urandom_range(0, 31));
      c_relu = $urandom_range(0, 1);
      gmode = (r < 2) ? 0 : 3;
      vmode = (r < 2) ? 0 : 1;
      for (int k = 0; k < c_n; k++)
        pdata[k] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 600) - 300;
      run_pass($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
